// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, op type and the per-requester operand bundle.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 3'b000;
  localparam alu_op_t ALU_SLL  = 3'b001;
  localparam alu_op_t ALU_SLT  = 3'b010;
  localparam alu_op_t ALU_SLTU = 3'b011;
  localparam alu_op_t ALU_XOR  = 3'b100;
  localparam alu_op_t ALU_SR   = 3'b101;
  localparam alu_op_t ALU_OR   = 3'b110;
  localparam alu_op_t ALU_AND  = 3'b111;

  typedef struct packed {
    logic [31:0] src_a;
    logic [31:0] src_b;
    alu_op_t     op;
    logic        alt;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU; alt selects sub for ADD and arithmetic shift for SR.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  alu_op_t     op,
  input  logic        alt,
  output logic [31:0] res
);

  logic [4:0] shamt;
  assign shamt = src_b[4:0];

  always_comb begin
    res = '0;
    unique case (op)
      ALU_ADD:  res = alt ? (src_a - src_b) : (src_a + src_b);
      ALU_SLL:  res = src_a << shamt;
      ALU_SLT:  res = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: res = {31'b0, src_a < src_b};
      ALU_XOR:  res = src_a ^ src_b;
      ALU_SR:   res = alt ? 32'($signed(src_a) >>> shamt) : (src_a >> shamt);
      ALU_OR:   res = src_a | src_b;
      ALU_AND:  res = src_a & src_b;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb_rr_pick.sv
// Stateless round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N   = 2,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  int unsigned j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      j = (int'(ptr_i) + off) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin share of one ALU among NREQ requesters with a one-entry tagged response buffer.
// Optional sticky-priority lock enabled by defining ALU_SHARE_ARB_LOCK_EN.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_src_a,
  input  logic [NREQ*32-1:0] req_src_b,
  input  logic [NREQ*3-1:0] req_op,
  input  logic [NREQ-1:0]   req_alt,
`ifdef ALU_SHARE_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_res,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_res_q, rsp_res_d;

  logic [NREQ-1:0] gnt_rr, gnt;
  logic [IDW-1:0]  idx_rr, gidx, gnext;
  logic            any_rr, can_accept, fire, keep_ptr;
  alu_req_t        sel;
  logic [31:0]     alu_res;

  rr_pick #(.N(NREQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_rr),
    .idx_o (idx_rr),
    .any_o (any_rr)
  );

`ifdef ALU_SHARE_ARB_LOCK_EN
  logic           lock_vld_q, lock_vld_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic           lock_hit;

  // Owner wins only while it is both locked and valid, otherwise plain round-robin.
  assign lock_hit = lock_vld_q & req_lock[lock_id_q] & req_valid[lock_id_q];

  always_comb begin
    gnt  = gnt_rr;
    gidx = idx_rr;
    if (lock_hit) begin
      gnt            = '0;
      gnt[lock_id_q] = 1'b1;
      gidx           = lock_id_q;
    end
  end

  assign keep_ptr = req_lock[gidx];

  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (fire) begin
      lock_vld_d = req_lock[gidx];
      lock_id_d  = gidx;
    end else if (lock_vld_q && !req_lock[lock_id_q]) begin
      lock_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  assign gnt      = gnt_rr;
  assign gidx     = idx_rr;
  assign keep_ptr = 1'b0;
`endif

  assign can_accept = (state_q == EMPTY) | rsp_ready;
  assign fire       = can_accept & any_rr & ~rst;
  assign req_ready  = fire ? gnt : '0;
  assign gnext      = (int'(gidx) == NREQ - 1) ? '0 : IDW'(gidx + 1'b1);

  always_comb begin
    sel.src_a = req_src_a[32*gidx +: 32];
    sel.src_b = req_src_b[32*gidx +: 32];
    sel.op    = req_op[3*gidx +: 3];
    sel.alt   = req_alt[gidx];
  end

  alu u_alu (
    .src_a (sel.src_a),
    .src_b (sel.src_b),
    .op    (sel.op),
    .alt   (sel.alt),
    .res   (alu_res)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_id_d  = rsp_id_q;
    rsp_res_d = rsp_res_q;
    unique case (state_q)
      EMPTY: if (fire) state_d = FULL;
      FULL: begin
        if (fire)           state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (fire) begin
      rsp_id_d  = gidx;
      rsp_res_d = alu_res;
      if (!keep_ptr) rr_ptr_d = gnext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      rr_ptr_q  <= '0;
      rsp_id_q  <= '0;
      rsp_res_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_id_q  <= rsp_id_d;
      rsp_res_q <= rsp_res_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign busy      = rsp_valid & ~rsp_ready;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb (NREQ=2); lock test under ALU_SHARE_ARB_LOCK_EN.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_src_a;
  logic [63:0] req_src_b;
  logic [5:0]  req_op;
  logic [1:0]  req_alt;
`ifdef ALU_SHARE_ARB_LOCK_EN
  logic [1:0]  req_lock;
`endif
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_res;
  logic        rsp_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src_a (req_src_a),
    .req_src_b (req_src_b),
    .req_op    (req_op),
    .req_alt   (req_alt),
`ifdef ALU_SHARE_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic alt);
    req_src_a[32*i +: 32] = a;
    req_src_b[32*i +: 32] = b;
    req_op[3*i +: 3]      = op;
    req_alt[i]            = alt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    set_req(0, 32'd1, 32'd1, 3'b000, 1'b0);
    set_req(1, 32'd2, 32'd2, 3'b000, 1'b0);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b id=%0d res=%h busy=%b exp all 0", rsp_valid, rsp_id, rsp_res, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    set_req(0, 32'd5, 32'd3, 3'b000, 1'b1);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 32'd2) begin
      errors++;
      $display("FAIL single_rsp got v=%b id=%0d res=%h exp v=1 id=0 res=2", rsp_valid, rsp_id, rsp_res);
    end
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_res !== 32'd2) begin
      errors++;
      $display("FAIL single_drain got v=%b res=%h exp v=0 res=2", rsp_valid, rsp_res);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_res;
    do_reset();
    set_req(0, 32'd10, 32'd1, 3'b000, 1'b0);
    set_req(1, 32'hF0, 32'h0F, 3'b100, 1'b0);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (req_ready !== exp_gnt[k]) begin
        errors++; $display("FAIL cont_grant[%0d] got=%b exp=%b", k, req_ready, exp_gnt[k]);
      end
      @(posedge clk); #1;
      exp_res = (k % 2 == 0) ? 32'd11 : 32'hFF;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2) || rsp_res !== exp_res) begin
        errors++;
        $display("FAIL cont_rsp[%0d] got v=%b id=%0d res=%h exp v=1 id=%0d res=%h",
                 k, rsp_valid, rsp_id, rsp_res, k % 2, exp_res);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 2'b10; rsp_ready = 1'b0;
    set_req(1, 32'h100, 32'h001, 3'b110, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 2'b00 || busy !== 1'b1 || rsp_valid !== 1'b1 ||
          rsp_id !== 1'b1 || rsp_res !== 32'hFF) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rdy=%b busy=%b v=%b id=%0d res=%h exp rdy=00 busy=1 v=1 id=1 res=ff",
                 k, req_ready, busy, rsp_valid, rsp_id, rsp_res);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b busy=%b exp rdy=10 busy=0", req_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 32'h101) begin
      errors++;
      $display("FAIL bp_rsp got v=%b id=%0d res=%h exp v=1 id=1 res=101", rsp_valid, rsp_id, rsp_res);
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b1 || rsp_res !== 32'h101) begin
      errors++;
      $display("FAIL bp_drain got v=%b id=%0d res=%h exp v=0 id=1 res=101", rsp_valid, rsp_id, rsp_res);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va  [8] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h0000F0F0};
    logic [31:0] vb  [8] = '{32'h1, 32'h3F, 32'h1, 32'h1, 32'h1, 32'h21, 32'h1F, 32'h0000FF00};
    logic [2:0]  vop [8] = '{3'b000, 3'b101, 3'b010, 3'b011, 3'b000, 3'b001, 3'b101, 3'b111};
    logic        valt[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] vexp[8] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0,
                             32'h0, 32'h2, 32'h1, 32'h0000F000};
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      set_req(0, va[k], vb[k], vop[k], valt[k]);
      req_valid = 2'b01;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== vexp[k]) begin
        errors++;
        $display("FAIL arith[%0d] got v=%b id=%0d res=%h exp v=1 id=0 res=%h",
                 k, rsp_valid, rsp_id, rsp_res, vexp[k]);
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    set_req(0, 32'd7, 32'd7, 3'b000, 1'b0);
    req_valid = 2'b01; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got v=%b exp=1", rsp_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got v=%b exp=0", rsp_valid); end
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got v=%b exp=0", rsp_valid); end
    @(negedge clk);
    set_req(1, 32'd1, 32'd1, 3'b000, 1'b0);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_ptr got rdy=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

`ifdef ALU_SHARE_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] vv [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    logic [1:0] vl [4] = '{2'b10, 2'b10, 2'b10, 2'b00};
    logic [1:0] eg [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    req_lock = '0;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 32'd1, 32'd1, 3'b000, 1'b0);
    set_req(1, 32'd2, 32'd2, 3'b000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      req_valid = vv[k]; req_lock = vl[k];
      #1;
      checks++;
      if (req_ready !== eg[k]) begin
        errors++; $display("FAIL lock_grant[%0d] got=%b exp=%b", k, req_ready, eg[k]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = '0; req_lock = '0;
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_src_a = '0; req_src_b = '0; req_op = '0; req_alt = '0;
`ifdef ALU_SHARE_ARB_LOCK_EN
    req_lock = '0;
`endif
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_arith();
    test_reset_mid_op();
`ifdef ALU_SHARE_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
